// File: rtl/dp_pkg.sv
// Shared encodings for the sequenced datapath: command kinds, ALU ops,
// shifter modes and status-bit positions.
package dp_pkg;

   typedef enum logic [1:0] {
      KIND_MOVI = 2'b00,
      KIND_ALU  = 2'b01,
      KIND_CMP  = 2'b10,
      KIND_MVN  = 2'b11
   } cmd_kind_t;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_AND  = 2'b10,
      OP_NOTB = 2'b11
   } aluop_t;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_t;

   // Bit positions inside the {Z,V,N} status vector
   localparam int unsigned Z_BIT = 2;
   localparam int unsigned V_BIT = 1;
   localparam int unsigned N_BIT = 0;

endpackage

// File: rtl/dp_regfile.sv
// Register file: one synchronous write port, two combinational read ports
// (operand fetch and debug), asynchronously cleared to zero.
module dp_regfile
   import dp_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8,
   localparam int unsigned RA_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [RA_W-1:0]   db_addr,
   output logic [DATA_W-1:0] db_data
);

   logic [DATA_W-1:0] regs [NREGS];

   // Storage: cleared on reset, single write per cycle otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data = regs[ra_addr];
   assign db_data = regs[db_addr];

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle datapath with its own operation sequencer. One command is
// accepted over valid/ready and walked through fetch, execute and write-back.
module seq_datapath
   import dp_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 8,
   localparam int unsigned RA_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_kind,
   input  logic [1:0]        cmd_aluop,
   input  logic [1:0]        cmd_shift,
   input  logic [RA_W-1:0]   cmd_rd,
   input  logic [RA_W-1:0]   cmd_rn,
   input  logic [RA_W-1:0]   cmd_rm,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              done,
   output logic [DATA_W-1:0] result_out,
   output logic [2:0]        status_out,
   input  logic [RA_W-1:0]   dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOADB = 3'd1;
   localparam logic [2:0] S_LOADA = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_WB    = 3'd4;

   logic [2:0]        state_q;
   cmd_kind_t         kind_q;
   aluop_t            aluop_q;
   shift_t            shift_q;
   logic [RA_W-1:0]   rd_q, rn_q, rm_q;
   logic [DATA_W-1:0] imm_q, a_q, b_q, c_q;
   logic [2:0]        status_q;
   logic              done_q;

   logic [RA_W-1:0]   rf_raddr;
   logic [DATA_W-1:0] rf_rdata;
   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;

   aluop_t            op_eff;
   logic [DATA_W-1:0] b_sh;
   logic [DATA_W-1:0] sum, diff, alu_res;
   logic [2:0]        flags;

   assign cmd_ready  = (state_q == S_IDLE) & reset_n;
   assign done       = done_q;
   assign result_out = c_q;
   assign status_out = status_q;

   // The single operand read port serves B in LOADB and A in LOADA
   assign rf_raddr = (state_q == S_LOADA) ? rn_q : rm_q;
   assign rf_we    = (state_q == S_WB);
   assign rf_wdata = (kind_q == KIND_MOVI) ? imm_q : c_q;

   dp_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .waddr   (rd_q),
      .wdata   (rf_wdata),
      .ra_addr (rf_raddr),
      .ra_data (rf_rdata),
      .db_addr (dbg_addr),
      .db_data (dbg_data)
   );

   // Effective ALU op: MVN always inverts B, CMP always subtracts
   always_comb begin
      op_eff = aluop_q;
      if (kind_q == KIND_MVN)      op_eff = OP_NOTB;
      else if (kind_q == KIND_CMP) op_eff = OP_SUB;
   end

   // One-bit shifter on the B operand
   always_comb begin
      b_sh = b_q;
      case (shift_q)
         SH_LSL1: b_sh = {b_q[DATA_W-2:0], 1'b0};
         SH_LSR1: b_sh = {1'b0, b_q[DATA_W-1:1]};
         SH_ASR1: b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
         default: b_sh = b_q;
      endcase
   end

   assign sum  = a_q + b_sh;
   assign diff = a_q - b_sh;

   // ALU result and {Z,V,N} flags
   always_comb begin
      alu_res = '0;
      flags   = '0;
      case (op_eff)
         OP_ADD: begin
            alu_res      = sum;
            flags[V_BIT] = (a_q[DATA_W-1] == b_sh[DATA_W-1]) &
                           (sum[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_SUB: begin
            alu_res      = diff;
            flags[V_BIT] = (a_q[DATA_W-1] != b_sh[DATA_W-1]) &
                           (diff[DATA_W-1] != a_q[DATA_W-1]);
         end
         OP_AND:  alu_res = a_q & b_sh;
         default: alu_res = ~b_sh;
      endcase
      flags[Z_BIT] = (alu_res == '0);
      flags[N_BIT] = alu_res[DATA_W-1];
   end

   // Sequencer: command capture, operand/result registers, done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         kind_q   <= KIND_MOVI;
         aluop_q  <= OP_ADD;
         shift_q  <= SH_NONE;
         rd_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  kind_q  <= cmd_kind_t'(cmd_kind);
                  aluop_q <= aluop_t'(cmd_aluop);
                  shift_q <= shift_t'(cmd_shift);
                  rd_q    <= cmd_rd;
                  rn_q    <= cmd_rn;
                  rm_q    <= cmd_rm;
                  imm_q   <= cmd_imm;
                  state_q <= (cmd_kind_t'(cmd_kind) == KIND_MOVI) ? S_WB : S_LOADB;
               end
            end
            S_LOADB: begin
               b_q     <= rf_rdata;
               state_q <= (kind_q == KIND_MVN) ? S_EXEC : S_LOADA;
            end
            S_LOADA: begin
               a_q     <= rf_rdata;
               state_q <= S_EXEC;
            end
            S_EXEC: begin
               c_q      <= alu_res;
               status_q <= flags;
               if (kind_q == KIND_CMP) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_WB: begin
               state_q <= S_IDLE;
               done_q  <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: a 16-bit/8-register instance checked
// against a reference model through a scoreboard, plus an 8-bit/4-register
// instance for narrow-width arithmetic shift.
module tb_seq_datapath;

   typedef struct {
      string       tag;
      int          lat;
      logic [2:0]  rd;
      logic [15:0] rval;
      logic [15:0] cval;
      logic [2:0]  st;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid16, valid8;
   logic [1:0]  kind_f, op_f, sh_f;
   logic [2:0]  rd_f, rn_f, rm_f;
   logic [15:0] imm_f;

   logic        ready16, done16;
   logic [15:0] res16, dbg16;
   logic [2:0]  st16, dbga16;

   logic        ready8, done8;
   logic [7:0]  res8, dbg8;
   logic [2:0]  st8;
   logic [1:0]  dbga8;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   logic [15:0] mr[8];
   logic [15:0] mc;
   logic [2:0]  ms;

   always #5 clk = ~clk;

   seq_datapath #(.DATA_W(16), .NREGS(8)) dut16 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(valid16), .cmd_ready(ready16),
      .cmd_kind(kind_f), .cmd_aluop(op_f), .cmd_shift(sh_f),
      .cmd_rd(rd_f), .cmd_rn(rn_f), .cmd_rm(rm_f), .cmd_imm(imm_f),
      .done(done16), .result_out(res16), .status_out(st16),
      .dbg_addr(dbga16), .dbg_data(dbg16)
   );

   seq_datapath #(.DATA_W(8), .NREGS(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .cmd_valid(valid8), .cmd_ready(ready8),
      .cmd_kind(kind_f), .cmd_aluop(op_f), .cmd_shift(sh_f),
      .cmd_rd(rd_f[1:0]), .cmd_rn(rn_f[1:0]), .cmd_rm(rm_f[1:0]), .cmd_imm(imm_f[7:0]),
      .done(done8), .result_out(res8), .status_out(st8),
      .dbg_addr(dbga8), .dbg_data(dbg8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] shf(input logic [1:0] s, input logic [15:0] b);
      case (s)
         2'b00:   return b;
         2'b01:   return b << 1;
         2'b10:   return b >> 1;
         default: return (b >> 1) | (b & 16'h8000);
      endcase
   endfunction

   // Returns {Z,V,N, result}; overflow judged on true signed integer range
   function automatic logic [18:0] model_alu(input logic [1:0] op, input logic [15:0] a,
                                             input logic [15:0] bs);
      int          sa, sb, s;
      logic [15:0] r;
      logic        v;
      sa = $signed(a);
      sb = $signed(bs);
      v  = 1'b0;
      s  = 0;
      case (op)
         2'b00: begin s = sa + sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
         2'b01: begin s = sa - sb; r = s[15:0]; v = (s > 32767) || (s < -32768); end
         2'b10: r = a & bs;
         default: r = ~bs;
      endcase
      return {(r == 16'h0), v, r[15], r};
   endfunction

   task automatic drive(input logic [1:0] kind, op, sh, input logic [2:0] rd, rn, rm,
                        input logic [15:0] imm);
      kind_f = kind; op_f = op; sh_f = sh;
      rd_f = rd; rn_f = rn; rm_f = rm; imm_f = imm;
   endtask

   task automatic cmd16(input string tag, input logic [1:0] kind, op, sh,
                        input logic [2:0] rd, rn, rm, input logic [15:0] imm, input bit hold);
      exp_t        e;
      logic [18:0] m;
      int          n;
      int          extra;
      e.tag = tag;
      e.rd  = rd;
      case (kind)
         2'b00: begin e.lat = 1; mr[rd] = imm; end
         2'b01: begin
            e.lat = 4; m = model_alu(op, mr[rn], shf(sh, mr[rm]));
            mc = m[15:0]; ms = m[18:16]; mr[rd] = mc;
         end
         2'b10: begin
            e.lat = 3; m = model_alu(2'b01, mr[rn], shf(sh, mr[rm]));
            mc = m[15:0]; ms = m[18:16];
         end
         default: begin
            e.lat = 3; m = model_alu(2'b11, 16'h0, shf(sh, mr[rm]));
            mc = m[15:0]; ms = m[18:16]; mr[rd] = mc;
         end
      endcase
      e.rval = mr[rd];
      e.cval = mc;
      e.st   = ms;
      sb.push_back(e);

      @(negedge clk);
      chk({tag, ".ready"}, ready16, 1);
      drive(kind, op, sh, rd, rn, rm, imm);
      valid16 = 1'b1;
      @(posedge clk); #1;
      if (!hold) valid16 = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done16 && n < 20);
      valid16 = 1'b0;
      if (hold) begin
         extra = 0;
         repeat (6) begin
            @(posedge clk); #1;
            if (done16) extra++;
         end
         chk({tag, ".extra_done"}, extra, 0);
      end

      e = sb.pop_front();
      chk({e.tag, ".latency"}, n, e.lat);
      dbga16 = e.rd; #1;
      chk({e.tag, ".reg"},    dbg16, e.rval);
      chk({e.tag, ".result"}, res16, e.cval);
      chk({e.tag, ".status"}, st16,  e.st);
   endtask

   task automatic cmd8(input string tag, input logic [1:0] kind, op, sh,
                       input logic [1:0] rd, rn, rm, input logic [7:0] imm,
                       input int lat, input logic [7:0] rval, cval, input logic [2:0] st);
      exp_t e;
      int   n;
      e.tag = tag; e.lat = lat; e.rd = {1'b0, rd};
      e.rval = {8'h0, rval}; e.cval = {8'h0, cval}; e.st = st;
      sb.push_back(e);

      @(negedge clk);
      chk({tag, ".ready"}, ready8, 1);
      drive(kind, op, sh, {1'b0, rd}, {1'b0, rn}, {1'b0, rm}, {8'h0, imm});
      valid8 = 1'b1;
      @(posedge clk); #1;
      valid8 = 1'b0;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done8 && n < 20);

      e = sb.pop_front();
      chk({e.tag, ".latency"}, n, e.lat);
      dbga8 = e.rd[1:0]; #1;
      chk({e.tag, ".reg"},    {8'h0, dbg8}, e.rval);
      chk({e.tag, ".result"}, {8'h0, res8}, e.cval);
      chk({e.tag, ".status"}, st8,          e.st);
   endtask

   initial begin
      int cnt;
      reset_n = 1'b0;
      valid16 = 1'b0;
      valid8  = 1'b0;
      drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0);
      dbga16 = 3'd0;
      dbga8  = 2'd0;
      for (int i = 0; i < 8; i++) mr[i] = 16'h0;
      mc = 16'h0;
      ms = 3'b000;

      // Reset state
      #1;
      chk("rst.ready16", ready16, 0);
      chk("rst.ready8",  ready8,  0);
      chk("rst.done16",  done16,  0);
      chk("rst.result",  res16,   16'h0);
      chk("rst.status",  st16,    3'b000);
      chk("rst.dbg",     dbg16,   16'h0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rel.ready16", ready16, 1);

      // Main function, 16-bit instance
      cmd16("movi_r0",  2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0007, 0);
      cmd16("movi_r1",  2'b00, 2'b00, 2'b00, 3'd1, 3'd0, 3'd0, 16'h0002, 0);
      cmd16("add_lsl",  2'b01, 2'b00, 2'b01, 3'd2, 3'd1, 3'd0, 16'h0,    0);
      chk("add_lsl.const", res16, 16'h0010);
      cmd16("and_lsl",  2'b01, 2'b10, 2'b01, 3'd2, 3'd1, 3'd0, 16'h0,    0);
      cmd16("cmp_lsl",  2'b10, 2'b00, 2'b01, 3'd2, 3'd1, 3'd0, 16'h0,    0);
      chk("cmp_lsl.const", res16, 16'hFFF4);
      cmd16("mvn_lsl",  2'b11, 2'b00, 2'b01, 3'd2, 3'd0, 3'd0, 16'h0,    0);
      cmd16("movi_r4",  2'b00, 2'b00, 2'b00, 3'd4, 3'd0, 3'd0, 16'h7FFF, 0);
      cmd16("movi_r5",  2'b00, 2'b00, 2'b00, 3'd5, 3'd0, 3'd0, 16'h0001, 0);
      cmd16("add_ovf",  2'b01, 2'b00, 2'b00, 3'd6, 3'd4, 3'd5, 16'h0,    0);
      chk("add_ovf.const_st", st16, 3'b011);
      cmd16("sub_zero", 2'b01, 2'b01, 2'b00, 3'd7, 3'd5, 3'd5, 16'h0,    0);
      chk("sub_zero.const_st", st16, 3'b100);
      cmd16("lsr_sub",  2'b01, 2'b01, 2'b10, 3'd5, 3'd4, 3'd6, 16'h0,    0);

      dbga16 = 3'd0; #1; chk("final.r0", dbg16, 16'h0007);
      dbga16 = 3'd2; #1; chk("final.r2", dbg16, 16'hFFF1);
      dbga16 = 3'd6; #1; chk("final.r6", dbg16, 16'h8000);

      // cmd_valid held through a busy command: one completion only
      cmd16("hold_add", 2'b01, 2'b00, 2'b00, 3'd3, 3'd1, 3'd0, 16'h0,    1);

      // Reset during LOADA aborts the command
      @(negedge clk);
      drive(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 3'd1, 16'h0);
      valid16 = 1'b1;
      @(posedge clk); #1;
      valid16 = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("abort.ready_low", ready16, 0);
      chk("abort.done_low",  done16,  0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) mr[i] = 16'h0;
      mc = 16'h0;
      ms = 3'b000;
      cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done16) cnt++;
      end
      chk("abort.no_done", cnt, 0);
      chk("abort.ready",   ready16, 1);
      dbga16 = 3'd3; #1;
      chk("abort.r3",      dbg16, 16'h0);
      chk("abort.result",  res16, 16'h0);

      // Narrow instance: arithmetic shift right of a negative byte
      cmd8("w8_movi", 2'b00, 2'b00, 2'b00, 2'd1, 2'd0, 2'd0, 8'h80, 1, 8'h80, 8'h00, 3'b000);
      cmd8("w8_asr",  2'b01, 2'b00, 2'b11, 2'd2, 2'd0, 2'd1, 8'h00, 4, 8'hC0, 8'hC0, 3'b001);

      chk("sb.empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
